// File: rtl/ocapi_rd_responder.sv
// ocapi_rd_responder
// Host-memory read responder for the OpenCAPI request/response loop.
// Accepts line-read requests into a circular FIFO, ages each entry by a fixed
// latency, and answers in order with two 512-bit beats per 128 B cache line.
// Beat data is the byte address of each 64-bit word, so the requester can
// check both ordering and addressing.

module ocapi_rd_responder #(
    parameter int addr_width = 64,
    parameter int tag_width  = 8,
    parameter int depth      = 16,
    parameter int latency    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req_v,
    output logic                    i_req_r,
    input  logic [addr_width-1:0]   i_req_ea,
    input  logic [tag_width-1:0]    i_req_tag,
    output logic                    o_rsp_v,
    input  logic                    o_rsp_r,
    output logic [tag_width-1:0]    o_rsp_tag,
    output logic                    o_rsp_beat,
    output logic                    o_rsp_last,
    output logic [511:0]            o_rsp_data,
    output logic [$clog2(depth):0]  o_outstanding
);

    localparam int ptr_w  = $clog2(depth);
    localparam int occ_w  = ptr_w + 1;
    localparam int line_w = addr_width - 7;

    localparam logic [occ_w-1:0] full_lvl = occ_w'(depth);
    localparam logic [7:0]       cnt_load = 8'(latency - 1);

    // Which half of the line the head entry is presenting.
    typedef enum logic {
        beat_lo = 1'b0,
        beat_hi = 1'b1
    } beat_e;

    // FIFO storage: 128 B line address, tag, and remaining latency per entry.
    logic [line_w-1:0]    line_mem [depth];
    logic [tag_width-1:0] tag_mem  [depth];
    logic [7:0]           cnt_q    [depth];

    logic [ptr_w-1:0] wr_ptr_q;
    logic [ptr_w-1:0] rd_ptr_q;
    logic [occ_w-1:0] occ_q;
    logic [occ_w-1:0] occ_d;
    logic             req_r_q;
    beat_e            beat_q;
    beat_e            beat_d;

    logic        accept;
    logic        head_ready;
    logic        rsp_fire;
    logic        pop;
    logic [63:0] line_base;
    logic [63:0] beat_off;

    // The low seven address bits only select bytes inside the line.
    logic unused_ea_low;
    assign unused_ea_low = ^i_req_ea[6:0];

    assign accept     = i_req_v & req_r_q;
    assign head_ready = (occ_q != '0) && (cnt_q[rd_ptr_q] == 8'd0);
    assign rsp_fire   = head_ready & o_rsp_r;
    assign pop        = rsp_fire & (beat_q == beat_hi);

    // Occupancy after this edge; accept and pop together cancel out.
    always_comb begin
        // NOTE: assigning a default before the case keeps this block free of inferred latches.
        occ_d = occ_q;
        unique case ({accept, pop})
            2'b10:   occ_d = occ_q + occ_w'(1);
            2'b01:   occ_d = occ_q - occ_w'(1);
            default: ;
        endcase
    end

    // Pointers, occupancy and the registered request-ready flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking assignments here so every flop samples pre-edge values.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            req_r_q  <= 1'b0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + ptr_w'(1);
            if (pop)    rd_ptr_q <= rd_ptr_q + ptr_w'(1);
            occ_q   <= occ_d;
            // Ready comes from the next occupancy, so a pop while full re-opens it a cycle later.
            req_r_q <= (occ_d < full_lvl);
        end
    end

    // Latency counters: load on accept, count down freely regardless of stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < depth; i++) cnt_q[i] <= 8'd0;
        end else begin
            for (int i = 0; i < depth; i++) begin
                if (cnt_q[i] != 8'd0) cnt_q[i] <= cnt_q[i] - 8'd1;
            end
            if (accept) cnt_q[wr_ptr_q] <= cnt_load;
        end
    end

    // Payload storage written on accept.
    always_ff @(posedge clk) begin
        // NOTE: payload RAM has no reset; outputs are gated by head_ready, so stale contents are never visible.
        if (accept) begin
            line_mem[wr_ptr_q] <= i_req_ea[addr_width-1:7];
            tag_mem[wr_ptr_q]  <= i_req_tag;
        end
    end

    // Beat pointer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) beat_q <= beat_lo;
        else       beat_q <= beat_d;
    end

    // Beat pointer next state: advances only on a response handshake.
    always_comb begin
        beat_d = beat_q;
        if (rsp_fire) beat_d = (beat_q == beat_lo) ? beat_hi : beat_lo;
    end

    // Response outputs: head entry only, zero whenever nothing is presented.
    always_comb begin
        o_rsp_v    = head_ready;
        o_rsp_beat = head_ready & (beat_q == beat_hi);
        o_rsp_last = head_ready & (beat_q == beat_hi);
        o_rsp_tag  = '0;
        o_rsp_data = '0;
        line_base  = 64'({line_mem[rd_ptr_q], 7'b0});
        beat_off   = (beat_q == beat_hi) ? 64'd64 : 64'd0;
        if (head_ready) begin
            o_rsp_tag = tag_mem[rd_ptr_q];
            for (int w = 0; w < 8; w++) begin
                o_rsp_data[w*64 +: 64] = line_base + beat_off + 64'(w * 8);
            end
        end
    end

    assign i_req_r       = req_r_q;
    assign o_outstanding = occ_q;

endmodule

// File: tb/tb_ocapi_rd_responder.sv
// Testbench for ocapi_rd_responder: directed steps with a response scoreboard.

module tb_ocapi_rd_responder;

    localparam int addr_width = 64;
    localparam int tag_width  = 8;
    localparam int depth      = 16;
    localparam int latency    = 8;

    logic                   clk;
    logic                   reset;
    logic                   i_req_v;
    logic                   i_req_r;
    logic [addr_width-1:0]  i_req_ea;
    logic [tag_width-1:0]   i_req_tag;
    logic                   o_rsp_v;
    logic                   o_rsp_r;
    logic [tag_width-1:0]   o_rsp_tag;
    logic                   o_rsp_beat;
    logic                   o_rsp_last;
    logic [511:0]           o_rsp_data;
    logic [$clog2(depth):0] o_outstanding;

    ocapi_rd_responder #(
        .addr_width(addr_width),
        .tag_width (tag_width),
        .depth     (depth),
        .latency   (latency)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req_v      (i_req_v),
        .i_req_r      (i_req_r),
        .i_req_ea     (i_req_ea),
        .i_req_tag    (i_req_tag),
        .o_rsp_v      (o_rsp_v),
        .o_rsp_r      (o_rsp_r),
        .o_rsp_tag    (o_rsp_tag),
        .o_rsp_beat   (o_rsp_beat),
        .o_rsp_last   (o_rsp_last),
        .o_rsp_data   (o_rsp_data),
        .o_outstanding(o_outstanding)
    );

    typedef struct {
        logic [7:0]  tag;
        logic [63:0] ea;
        logic        beat;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hs_cnt = 0;
    int acc_cyc [256];
    int b0_cyc  [256];
    int b1_cyc  [256];

    logic [511:0] last_b0;
    logic [511:0] last_b1;
    logic         last_b1_last;
    logic [511:0] t1_b0;
    logic [511:0] t1_b1;

    logic         prev_stall = 1'b0;
    logic [7:0]   prev_tag;
    logic         prev_beat;
    logic [511:0] prev_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wide(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference data: each word carries its own byte address.
    function automatic logic [511:0] exp_data(input logic [63:0] ea, input logic b);
        logic [511:0] d;
        logic [63:0]  base;
        base = {ea[63:7], 7'b0};
        for (int w = 0; w < 8; w++) d[w*64 +: 64] = base + (b ? 64'd64 : 64'd0) + 64'(w) * 64'd8;
        return d;
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_v", 64'(o_rsp_v), 64'd1);
                chk("hold_tag", 64'(o_rsp_tag), 64'(prev_tag));
                chk("hold_beat", 64'(o_rsp_beat), 64'(prev_beat));
                chk_wide("hold_data", o_rsp_data, prev_data);
            end
            if (o_rsp_v && o_rsp_r) begin
                hs_cnt++;
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_underflow observed=tag %0h expected=no beat", o_rsp_tag);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_tag", 64'(o_rsp_tag), 64'(e.tag));
                    chk("rsp_beat", 64'(o_rsp_beat), 64'(e.beat));
                    chk("rsp_last", 64'(o_rsp_last), 64'(e.beat));
                    chk_wide("rsp_data", o_rsp_data, exp_data(e.ea, e.beat));
                    if (e.beat) begin
                        b1_cyc[e.tag] = cyc;
                        last_b1       = o_rsp_data;
                        last_b1_last  = o_rsp_last;
                    end else begin
                        b0_cyc[e.tag] = cyc;
                        last_b0       = o_rsp_data;
                    end
                end
            end
            prev_stall = o_rsp_v && !o_rsp_r;
            prev_tag   = o_rsp_tag;
            prev_beat  = o_rsp_beat;
            prev_data  = o_rsp_data;
            if (i_req_v && i_req_r) begin
                sb.push_back('{tag: i_req_tag, ea: i_req_ea, beat: 1'b0});
                sb.push_back('{tag: i_req_tag, ea: i_req_ea, beat: 1'b1});
                acc_cyc[i_req_tag] = cyc;
            end
        end
    end

    task automatic send(input logic [63:0] ea, input logic [7:0] tag);
        bit ok;
        ok        = 1'b0;
        i_req_v   = 1'b1;
        i_req_ea  = ea;
        i_req_tag = tag;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i_req_r) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_accept", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        i_req_v = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (o_rsp_v) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && o_outstanding == '0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs0;
        logic [63:0] rnd_ea;

        reset     = 1'b1;
        i_req_v   = 1'b0;
        i_req_ea  = '0;
        i_req_tag = '0;
        o_rsp_r   = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_v", 64'(o_rsp_v), 64'd0);
        chk("rst_req_r", 64'(i_req_r), 64'd0);
        chk("rst_outstanding", 64'(o_outstanding), 64'd0);
        chk("rst_tag", 64'(o_rsp_tag), 64'd0);
        chk("rst_beat", 64'(o_rsp_beat), 64'd0);
        chk("rst_last", 64'(o_rsp_last), 64'd0);
        chk_wide("rst_data", o_rsp_data, 512'd0);
        reset = 1'b0;
        #1;
        chk("rel_req_r_low", 64'(i_req_r), 64'd0);
        @(posedge clk);
        #1;
        chk("rel_req_r_high", 64'(i_req_r), 64'd1);

        // Single aligned request: fixed latency and address pattern.
        o_rsp_r = 1'b1;
        send(64'h8000, 8'h05);
        wait_idle("t1_idle", 100);
        chk("t1_b0_latency", 64'(b0_cyc[8'h05] - acc_cyc[8'h05]), 64'd8);
        chk("t1_b1_latency", 64'(b1_cyc[8'h05] - acc_cyc[8'h05]), 64'd9);
        chk("t1_b0_w0", last_b0[63:0], 64'h8000);
        chk("t1_b0_w7", last_b0[7*64 +: 64], 64'h8038);
        chk("t1_b1_w0", last_b1[63:0], 64'h8040);
        chk("t1_b1_last", 64'(last_b1_last), 64'd1);
        t1_b0 = last_b0;
        t1_b1 = last_b1;

        // Unaligned request maps to the same line.
        @(posedge clk);
        #1;
        send(64'h8075, 8'h06);
        wait_idle("t2_idle", 100);
        chk_wide("t2_b0_same_line", last_b0, t1_b0);
        chk_wide("t2_b1_same_line", last_b1, t1_b1);
        chk("t2_outstanding", 64'(o_outstanding), 64'd0);

        // Fill to depth with responses blocked, then drain.
        @(posedge clk);
        #1;
        o_rsp_r = 1'b0;
        for (int i = 0; i < depth; i++) send(64'h10000 + 64'(i) * 64'h80, 8'(i));
        chk("t3_full_req_r", 64'(i_req_r), 64'd0);
        chk("t3_full_outstanding", 64'(o_outstanding), 64'd16);
        hs0 = hs_cnt;
        o_rsp_r = 1'b1;
        for (int k = 0; k < 2 * depth; k++) begin
            @(negedge clk);
            chk("t3_stream_v", 64'(o_rsp_v), 64'd1);
            if (k == 1) chk("t3_req_r_before_pop", 64'(i_req_r), 64'd0);
            if (k == 2) chk("t3_req_r_after_pop", 64'(i_req_r), 64'd1);
        end
        wait_idle("t3_idle", 50);
        chk("t3_beats", 64'(hs_cnt - hs0), 64'd32);

        // Stall during beat 0 while a second request ages.
        @(posedge clk);
        #1;
        hs0 = hs_cnt;
        send(64'h3000, 8'h40);
        send(64'h3080, 8'h41);
        o_rsp_r = 1'b0;
        wait_valid("t4_valid");
        repeat (10) @(posedge clk);
        #1;
        o_rsp_r = 1'b1;
        wait_idle("t4_idle", 100);
        chk("t4_a_b1_follows", 64'(b1_cyc[8'h40] - b0_cyc[8'h40]), 64'd1);
        chk("t4_b_no_extra_wait", 64'(b0_cyc[8'h41] - b1_cyc[8'h40]), 64'd1);
        chk("t4_beats", 64'(hs_cnt - hs0), 64'd4);

        // Continuous streaming across pointer wrap.
        @(posedge clk);
        #1;
        for (int i = 0; i < 40; i++) begin
            rnd_ea = {$urandom, $urandom};
            send(rnd_ea, 8'(8'h80 + i));
        end
        wait_idle("t5_idle", 400);
        chk("t5_first_latency", 64'(b0_cyc[8'h80] - acc_cyc[8'h80]), 64'd8);
        for (int i = 1; i < 40; i++) begin
            chk("t5_no_gap", 64'(b0_cyc[8'h80 + i] - b1_cyc[8'h80 + i - 1]), 64'd1);
        end

        // Reset while beat 1 is pending with three requests outstanding.
        @(posedge clk);
        #1;
        o_rsp_r = 1'b0;
        send(64'h5000, 8'hC0);
        send(64'h5080, 8'hC1);
        send(64'h5100, 8'hC2);
        wait_valid("t6_valid");
        @(posedge clk);
        #1;
        o_rsp_r = 1'b1;
        @(posedge clk);
        #1;
        o_rsp_r = 1'b0;
        chk("t6_pending_beat", 64'(o_rsp_beat), 64'd1);
        chk("t6_pending_outstanding", 64'(o_outstanding), 64'd3);
        reset = 1'b1;
        #1;
        sb.delete();
        chk("t6_rst_v", 64'(o_rsp_v), 64'd0);
        chk("t6_rst_outstanding", 64'(o_outstanding), 64'd0);
        chk("t6_rst_req_r", 64'(i_req_r), 64'd0);
        chk_wide("t6_rst_data", o_rsp_data, 512'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_rel_req_r", 64'(i_req_r), 64'd1);
        o_rsp_r = 1'b1;
        send(64'h100, 8'h07);
        wait_idle("t6_idle", 100);
        chk("t6_b0_w0", last_b0[63:0], 64'h100);
        chk("t6_b0_w7", last_b0[7*64 +: 64], 64'h138);
        chk("t6_b1_w0", last_b1[63:0], 64'h140);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
